// File: rtl/kyber_decode_pkg.sv
// Shared definitions for the Kyber ByteDecode_d streaming unpacker.
//   KYBER_Q / KYBER_N : ring modulus and polynomial length
//   BYTE_CNT_W        : width of the per-polynomial byte counter (32*12 = 384 bytes max)
//   state_t           : control FSM states
//   ell_is_legal()    : coefficient widths the decoder accepts
package kyber_decode_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int BYTE_CNT_W = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic ell_is_legal(input logic [3:0] ell);
    case (ell)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_bit_buffer.sv
// Bit accumulator for the byte-to-coefficient unpacker.
// Bytes are appended above the cnt valid bits (LSB-first order); a pop removes
// the low ell bits. Push and pop can happen together: the byte then lands at
// cnt - ell. The caller guarantees a push only when cnt + 8 <= ACC_W.
// Ports:
//   clk, rst_n  : clock, async active-low reset (clears acc and cnt)
//   clear       : synchronous flush at the start of a polynomial
//   push        : append byte_data
//   byte_data   : incoming byte
//   pop         : drop the low ell bits
//   ell         : current coefficient width
//   cnt         : number of valid bits held
//   field       : acc[ell-1:0], zero-extended to MAX_ELL bits
module decode_bit_buffer #(
  parameter  int MAX_ELL = 12,
  localparam int ACC_W   = MAX_ELL + 7,
  localparam int CNT_W   = $clog2(ACC_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [7:0]         byte_data,
  input  logic               pop,
  input  logic [3:0]         ell,
  output logic [CNT_W-1:0]   cnt,
  output logic [MAX_ELL-1:0] field
);

  logic [ACC_W-1:0] acc, acc_pop, acc_next;
  logic [CNT_W-1:0] cnt_pop, cnt_next;

  // Bits above cnt are always zero, so OR-ing the shifted byte is an append.
  always_comb begin
    acc_pop  = pop ? (acc >> ell) : acc;
    cnt_pop  = pop ? (cnt - CNT_W'(ell)) : cnt;
    acc_next = acc_pop;
    cnt_next = cnt_pop;
    if (push) begin
      acc_next = acc_pop | (ACC_W'(byte_data) << cnt_pop);
      cnt_next = cnt_pop + CNT_W'(8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

  assign field = acc[MAX_ELL-1:0] & ~({MAX_ELL{1'b1}} << ell);

endmodule

// File: rtl/stream_byte_decode.sv
// Streaming ByteDecode_d: consumes 32*d bytes LSB-first and emits NUM_COEFFS
// d-bit coefficients, one per coeff_valid_o/coeff_ready_i handshake.
// Optional feature macro: DECODE_MODQ_EN -- for d=12, raw values >= KYBER_Q are
// reduced by one subtraction and flagged on modq_flag_o; otherwise the flag is 0.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start_i, ell_i      : begin a polynomial with width ell_i (latched)
//   busy_o              : polynomial in progress
//   cfg_err_o           : 1-cycle pulse after a start with an illegal width
//   in_data_i/valid/ready : byte input stream
//   coeff_o/valid/ready : coefficient output stream, coeff_o zero-extended
//   coeff_last_o        : marks coefficient NUM_COEFFS-1
//   modq_flag_o         : coefficient was reduced mod q
module stream_byte_decode
  import kyber_decode_pkg::*;
#(
  parameter int MAX_ELL    = 12,
  parameter int NUM_COEFFS = 256,
  parameter int KYBER_Q    = kyber_decode_pkg::KYBER_Q
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [3:0]         ell_i,
  output logic               busy_o,
  output logic               cfg_err_o,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [MAX_ELL-1:0] coeff_o,
  output logic               coeff_valid_o,
  input  logic               coeff_ready_i,
  output logic               coeff_last_o,
  output logic               modq_flag_o
);

  localparam int ACC_W = MAX_ELL + 7;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int CC_W  = $clog2(NUM_COEFFS);

  // A single conditional subtract only reduces fully when 2^MAX_ELL < 2*q.
  if (2 * KYBER_Q <= (1 << MAX_ELL)) begin : g_q_check
    $error("KYBER_Q too small for a single conditional subtract at MAX_ELL");
  end

  state_t                state, state_next;
  logic [3:0]            ell_q;
  logic [BYTE_CNT_W-1:0] bytes_taken;
  logic [CC_W-1:0]       coeff_idx;
  logic                  cfg_err_q;
  logic [CNT_W-1:0]      cnt;
  logic [MAX_ELL-1:0]    field;
  logic                  ell_ok, start_ok, start_bad;
  logic                  room, bytes_left, push, pop, is_last, last_pop;

  assign ell_ok    = ell_is_legal(ell_i) && (int'(ell_i) <= MAX_ELL);
  assign start_ok  = start_i && (state == ST_IDLE) && ell_ok;
  assign start_bad = start_i && (state == ST_IDLE) && !ell_ok;

  // Ready and valid are functions of registered state only.
  assign room          = (int'(cnt) + 8 <= ACC_W);
  assign bytes_left    = bytes_taken < (BYTE_CNT_W'(ell_q) << 5);
  assign in_ready_o    = (state == ST_RUN) && room && bytes_left;
  assign coeff_valid_o = (state == ST_RUN) && (cnt >= CNT_W'(ell_q));
  assign push          = in_valid_i && in_ready_o;
  assign pop           = coeff_valid_o && coeff_ready_i;
  assign is_last       = (coeff_idx == CC_W'(NUM_COEFFS - 1));
  assign last_pop      = pop && is_last;
  assign coeff_last_o  = coeff_valid_o && is_last;
  assign busy_o        = (state == ST_RUN);
  assign cfg_err_o     = cfg_err_q;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_ok) state_next = ST_RUN;
      ST_RUN:  if (last_pop) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ell_q       <= '0;
      bytes_taken <= '0;
      coeff_idx   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_err_q <= start_bad;
      if (start_ok) begin
        ell_q       <= ell_i;
        bytes_taken <= '0;
        coeff_idx   <= '0;
      end else begin
        if (push) bytes_taken <= bytes_taken + BYTE_CNT_W'(1);
        if (pop)  coeff_idx   <= coeff_idx + CC_W'(1);
      end
    end
  end

  decode_bit_buffer #(
    .MAX_ELL (MAX_ELL)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .push      (push),
    .byte_data (in_data_i),
    .pop       (pop),
    .ell       (ell_q),
    .cnt       (cnt),
    .field     (field)
  );

`ifdef DECODE_MODQ_EN
  logic over_q;
  assign over_q      = (ell_q == 4'd12) && (int'(field) >= KYBER_Q);
  assign coeff_o     = over_q ? MAX_ELL'(int'(field) - KYBER_Q) : field;
  assign modq_flag_o = coeff_valid_o && over_q;
`else
  assign coeff_o     = field;
  assign modq_flag_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_byte_decode.sv
// Bench for stream_byte_decode: random byte/ready traffic checked against a
// bit-stream model (coefficient i = stream bits i*d .. i*d+d-1), plus directed
// cases for reset, illegal width, ignored starts and reset mid-polynomial.
`timescale 1ns/1ps
module tb_stream_byte_decode;

  localparam int MAX_ELL = 12;
  localparam int N       = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic [3:0]         ell_i = '0;
  logic               busy_o, cfg_err_o;
  logic [7:0]         in_data_i = '0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [MAX_ELL-1:0] coeff_o;
  logic               coeff_valid_o;
  logic               coeff_ready_i = 1'b0;
  logic               coeff_last_o, modq_flag_o;

  always #5 clk = ~clk;

  stream_byte_decode #(.MAX_ELL(MAX_ELL), .NUM_COEFFS(N), .KYBER_Q(3329)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .ell_i         (ell_i),
    .busy_o        (busy_o),
    .cfg_err_o     (cfg_err_o),
    .in_data_i     (in_data_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .coeff_o       (coeff_o),
    .coeff_valid_o (coeff_valid_o),
    .coeff_ready_i (coeff_ready_i),
    .coeff_last_o  (coeff_last_o),
    .modq_flag_o   (modq_flag_o)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] stim_q[$];
  int         got_c[$];
  int         got_f[$];
  int         exp_c[N];
  int         exp_f[N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_stim(input int d, input int npre,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    stim_q.delete();
    if (npre > 0) stim_q.push_back(b0);
    if (npre > 1) stim_q.push_back(b1);
    if (npre > 2) stim_q.push_back(b2);
    while (stim_q.size() < 32 * d) stim_q.push_back(8'($urandom));
  endtask

  // Reference: treat the bytes as one LSB-first bit string and slice it.
  task automatic build_model(input int d);
    for (int i = 0; i < N; i++) begin
      int v;
      int f;
      v = 0;
      f = 0;
      for (int b = 0; b < d; b++) begin
        int p;
        p = i * d + b;
        v = v | (((int'(stim_q[p / 8]) >> (p % 8)) & 1) << b);
      end
`ifdef DECODE_MODQ_EN
      if (d == 12 && v >= 3329) begin
        v = v - 3329;
        f = 1;
      end
`endif
      exp_c[i] = v;
      exp_f[i] = f;
    end
  endtask

  task automatic run_poly(input int d, input int vpct, input int rpct,
                          input int stop_after, input bit poke);
    int                 bi, ci, cyc, stalls;
    bit                 holding;
    logic [MAX_ELL-1:0] hold_v;
    bi = 0; ci = 0; cyc = 0; stalls = 0; holding = 1'b0; hold_v = '0;
    got_c.delete();
    got_f.delete();
    build_model(d);
    @(negedge clk);
    start_i = 1'b1;
    ell_i   = 4'(d);
    @(negedge clk);
    start_i = 1'b0;
    #1 check_eq($sformatf("busy_after_start d=%0d", d), busy_o, 1);
    while (ci < N && cyc < 20000) begin
      in_valid_i    = (bi < 32 * d) && (($urandom % 100) < vpct);
      in_data_i     = in_valid_i ? stim_q[bi] : 8'($urandom);
      coeff_ready_i = ($urandom % 100) < rpct;
      start_i       = poke && (cyc == 20);
      ell_i         = start_i ? 4'd4 : 4'(d);
      #1;
      if (holding && !(coeff_valid_o && coeff_o == hold_v)) stalls++;
      holding = 1'b0;
      if (in_valid_i && in_ready_o) bi++;
      if (coeff_valid_o && coeff_ready_i) begin
        check_eq($sformatf("coeff[%0d] d=%0d", ci, d), coeff_o, exp_c[ci]);
        check_eq($sformatf("modq_flag[%0d] d=%0d", ci, d), modq_flag_o, exp_f[ci]);
        check_eq($sformatf("last[%0d] d=%0d", ci, d), coeff_last_o, (ci == N - 1));
        got_c.push_back(int'(coeff_o));
        got_f.push_back(int'(modq_flag_o));
        if (ci == N - 1) begin
          start_i = 1'b1;
          ell_i   = 4'd12;
        end
        ci++;
      end else if (coeff_valid_o) begin
        holding = 1'b1;
        hold_v  = coeff_o;
      end
      if (stop_after != 0 && bi >= stop_after) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start_i       = 1'b0;
    in_valid_i    = 1'b0;
    coeff_ready_i = 1'b0;
    if (stop_after == 0) begin
      check_eq($sformatf("coeff_count d=%0d", d), ci, N);
      check_eq($sformatf("bytes_used d=%0d", d), bi, 32 * d);
      check_eq($sformatf("stall_stable d=%0d", d), stalls, 0);
      #1;
      check_eq($sformatf("busy_end d=%0d", d), busy_o, 0);
      check_eq($sformatf("in_ready_end d=%0d", d), in_ready_o, 0);
      check_eq($sformatf("valid_end d=%0d", d), coeff_valid_o, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {busy_o, cfg_err_o, in_ready_o, coeff_valid_o, coeff_last_o,
                   modq_flag_o, coeff_o}, '0);
  endtask

  int ds[6] = '{1, 4, 5, 10, 11, 12};
  int a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    // d=12: 01 23 45 -> 0x301, 0x452
    fill_stim(12, 3, 8'h01, 8'h23, 8'h45);
    run_poly(12, 100, 100, 0, 1'b0);
    check_eq("d12_c0", got_c[0], 32'h301);
    check_eq("d12_c1", got_c[1], 32'h452);

    // d=1: A5 -> 1,0,1,0,0,1,0,1
    fill_stim(1, 1, 8'hA5, 8'h00, 8'h00);
    run_poly(1, 100, 100, 0, 1'b0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("d1_c%0d", i), got_c[i], a5[i]);

    // d=4: 3C -> C,3
    fill_stim(4, 1, 8'h3C, 8'h00, 8'h00);
    run_poly(4, 100, 100, 0, 1'b0);
    check_eq("d4_c0", got_c[0], 32'hC);
    check_eq("d4_c1", got_c[1], 32'h3);

    // d=12: FF FF FF -> mod-q reduction when enabled
    fill_stim(12, 3, 8'hFF, 8'hFF, 8'hFF);
    run_poly(12, 100, 100, 0, 1'b0);
`ifdef DECODE_MODQ_EN
    check_eq("ff_c0", got_c[0], 766);
    check_eq("ff_c1", got_c[1], 766);
    check_eq("ff_f0", got_f[0], 1);
    check_eq("ff_f1", got_f[1], 1);
`else
    check_eq("ff_c0", got_c[0], 32'hFFF);
    check_eq("ff_c1", got_c[1], 32'hFFF);
    check_eq("ff_f0", got_f[0], 0);
    check_eq("ff_f1", got_f[1], 0);
`endif

    // Random traffic with backpressure, with a start pulse mid-run on half of them
    for (int k = 0; k < 6; k++) begin
      fill_stim(ds[k], 0, 8'h00, 8'h00, 8'h00);
      run_poly(ds[k], int'($urandom_range(40, 100)), 30, 0, (k % 2) == 0);
    end

    // Illegal width
    @(negedge clk);
    start_i = 1'b1;
    ell_i   = 4'd7;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("cfg_err_pulse", cfg_err_o, 1);
    check_eq("cfg_err_busy", busy_o, 0);
    @(negedge clk);
    check_eq("cfg_err_clear", cfg_err_o, 0);
    check_eq("cfg_err_busy2", busy_o, 0);
    check_eq("cfg_err_in_ready", in_ready_o, 0);

    // Reset after 100 bytes at d=10, then a clean polynomial
    fill_stim(10, 0, 8'h00, 8'h00, 8'h00);
    run_poly(10, 100, 100, 100, 1'b0);
    check_eq("busy_before_reset", busy_o, 1);
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    fill_stim(10, 0, 8'h00, 8'h00, 8'h00);
    run_poly(10, 80, 60, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
